delay_arbiter: RTL

//  Shares one reloadable down-counter (timed-delay resource) between NREQ requesters.

---
 rtl/delay_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that lends a single reloadable down-counter to NREQ requesters.
// The owner holds the counter for iCount cycles, then receives a one-cycle oDone pulse.
module delay_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WORDSIZE = 8
) (
   input  logic                     iClk,
   input  logic                     iResetN,
   input  logic [NREQ-1:0]          iReq,
   input  logic [NREQ*WORDSIZE-1:0] iCount,
   output logic [NREQ-1:0]          oGrant,
   output logic [NREQ-1:0]          oDone,
   output logic                     oBusy,
   output logic [WORDSIZE-1:0]      oRemain
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PW-1:0]       r_ptr;
   logic [PW-1:0]       r_gidx;
   logic [PW-1:0]       w_pick;
   logic [PW-1:0]       w_gnext;
   logic                w_found;
   logic [NREQ-1:0]     w_onehot;
   logic [WORDSIZE-1:0] r_cnt;

   // First requester at or above the pointer, wrapping modulo NREQ
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!w_found && iReq[(32'(r_ptr) + i) % NREQ]) begin
            w_found = 1'b1;
            w_pick  = PW'((32'(r_ptr) + i) % NREQ);
         end
      end
   end

   assign w_gnext  = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
   assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;

   always_ff @(posedge iClk or negedge iResetN) begin
      if (!iResetN) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Abort is tested before expiry so a withdrawn request never yields oDone
   always_comb begin
      w_state_nxt = r_state;
      oGrant      = '0;
      oDone       = '0;
      case (r_state)
         IDLE: if (w_found) w_state_nxt = RUN;
         RUN: begin
            oGrant = w_onehot;
            if (!iReq[r_gidx])     w_state_nxt = IDLE;
            else if (r_cnt == '0)  w_state_nxt = DONE;
         end
         DONE: begin
            oDone       = w_onehot;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iResetN) begin
      if (!iResetN) begin
         r_ptr  <= '0;
         r_gidx <= '0;
         r_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_found) begin
               r_gidx <= w_pick;
               r_cnt  <= iCount[32'(w_pick)*WORDSIZE +: WORDSIZE] - 1'b1;
            end
            RUN: begin
               if (!iReq[r_gidx])     r_ptr <= w_gnext;
               else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
            end
            DONE: r_ptr <= w_gnext;
            default: ;
         endcase
      end
   end

   assign oBusy   = (r_state != IDLE);
   assign oRemain = r_cnt;

endmodule
